// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers, SRAM handshake FSM with configurable
// wait states, and a memory-mapped switch/hex I/O location.
module mem_access_unit #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Bus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_OE,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic [15:0] HEX_Data,
  output logic        Mem_Ready
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_CAP, RD_REL, WR_SETUP, WR_PULSE, WR_HOLD, WR_REL
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [15:0] r_mar, r_mdr, r_hex, r_addr_lat, r_data_lat;
  logic        r_ce_n, r_oe_n, r_we_n, r_data_oe, r_ready;
  logic        w_ce_n, w_oe_n, w_we_n, w_data_oe, w_ready;
  logic        w_io;

  // In IDLE the address about to be latched is still in MAR.
  assign w_io = (r_state == IDLE) ? (r_mar == IO_ADDR) : (r_addr_lat == IO_ADDR);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (!Mem_WE) begin
          w_next     = WR_SETUP;
          w_cnt_next = WS;
        end else if (!Mem_OE) begin
          w_next     = RD_WAIT;
          w_cnt_next = WS;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 3'd0) w_next = RD_CAP;
        else               w_cnt_next = r_cnt - 3'd1;
      end
      RD_CAP:  w_next = RD_REL;
      RD_REL:  if (Mem_OE) w_next = IDLE;
      WR_SETUP: begin
        w_next     = WR_PULSE;
        w_cnt_next = WS;
      end
      WR_PULSE: begin
        if (r_cnt == 3'd0) w_next = WR_HOLD;
        else               w_cnt_next = r_cnt - 3'd1;
      end
      WR_HOLD: w_next = WR_REL;
      WR_REL:  if (Mem_WE) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    // Strobes are decoded from the next state and registered, so the pins
    // change cleanly on the same edge as the state.
    w_ce_n    = 1'b1;
    w_oe_n    = 1'b1;
    w_we_n    = 1'b1;
    w_data_oe = 1'b0;
    w_ready   = 1'b0;
    case (w_next)
      RD_WAIT: begin
        w_ce_n = w_io;
        w_oe_n = w_io;
      end
      RD_CAP: begin
        w_ce_n  = w_io;
        w_oe_n  = w_io;
        w_ready = 1'b1;
      end
      WR_SETUP: begin
        w_ce_n    = w_io;
        w_data_oe = 1'b1;
      end
      WR_PULSE: begin
        w_ce_n    = w_io;
        w_we_n    = w_io;
        w_data_oe = 1'b1;
      end
      WR_HOLD: begin
        w_ce_n    = w_io;
        w_data_oe = 1'b1;
        w_ready   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_data_oe  <= 1'b0;
      r_ready    <= 1'b0;
      r_mar      <= 16'h0;
      r_mdr      <= 16'h0;
      r_hex      <= 16'h0;
      r_addr_lat <= 16'h0;
      r_data_lat <= 16'h0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_ce_n    <= w_ce_n;
      r_oe_n    <= w_oe_n;
      r_we_n    <= w_we_n;
      r_data_oe <= w_data_oe;
      r_ready   <= w_ready;

      if (r_state == IDLE && w_next != IDLE) begin
        r_addr_lat <= r_mar;
        r_data_lat <= r_mdr;
      end

      if (LD_MAR) r_mar <= Bus;

      // A read in flight owns MDR; bus loads only land while no read is requested.
      if (r_state == RD_CAP)
        r_mdr <= (r_addr_lat == IO_ADDR) ? Switches : Data_from_SRAM;
      else if (LD_MDR && Mem_OE)
        r_mdr <= Bus;

      if (r_state == WR_HOLD && r_addr_lat == IO_ADDR) r_hex <= r_data_lat;
    end
  end

  assign MAR          = r_mar;
  assign MDR          = r_mdr;
  assign ADDR         = {4'b0, r_addr_lat};
  assign Data_to_SRAM = r_data_lat;
  assign Data_OE      = r_data_oe;
  assign SRAM_CE_n    = r_ce_n;
  assign SRAM_OE_n    = r_oe_n;
  assign SRAM_WE_n    = r_we_n;
  assign HEX_Data     = r_hex;
  assign Mem_Ready    = r_ready;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_STATES, default 1, means extra SRAM access cycles (legal 0..7).
REQ-002 Parameter IO_ADDR, default 16'hFFFF, is the memory-mapped switch/hex address.
REQ-003 Clk  in  1  is the single rising-edge clock.
REQ-004 Reset_n  in  1  is the asynchronous, active-low reset.
REQ-005 Bus  in  16  is the datapath bus value.
REQ-006 LD_MAR, LD_MDR  in  1 each  are load strobes from the control unit.
REQ-007 Mem_OE, Mem_WE  in  1 each  are active-low read/write requests from the control unit.
REQ-008 Switches  in  16  is the board switch value returned on IO_ADDR reads.
REQ-009 Data_from_SRAM  in  16  is the SRAM read data.
REQ-010 MAR, MDR  out  16 each  are the address and data registers.
REQ-011 ADDR  out  20  is the SRAM address, {4'b0, latched MAR}.
REQ-012 Data_to_SRAM  out  16  is the write data; Data_OE  out  1  is high while the write data is driven.
REQ-013 SRAM_CE_n, SRAM_OE_n, SRAM_WE_n  out  1 each  are the active-low SRAM strobes.
REQ-014 HEX_Data  out  16  is the hex display register.
REQ-015 Mem_Ready  out  1  is a one-cycle pulse marking access completion.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_WAIT, RD_CAP, RD_REL, WR_SETUP, WR_PULSE, WR_HOLD and WR_REL.
REQ-017 In IDLE, Mem_WE==0 -> WR_SETUP; else Mem_OE==0 -> RD_WAIT; a write SHALL take priority if both requests are low.
REQ-018 On leaving IDLE, MAR SHALL be latched into addr_lat, MDR into data_lat, and cnt loaded with WAIT_STATES.
REQ-019 ADDR and Data_to_SRAM SHALL use only the latched values, so LD_MAR or LD_MDR during an access does not disturb it.
REQ-020 In RD_WAIT: CE_n=0, OE_n=0, cnt decrements each cycle, and cnt==0 -> RD_CAP.
REQ-021 For WAIT_STATES=0, RD_WAIT SHALL last exactly 1 cycle.
REQ-022 In RD_CAP (1 cycle): CE_n=0, OE_n=0, Mem_Ready=1, -> RD_REL.
REQ-023 In RD_CAP, MDR <= Switches if addr_lat==IO_ADDR, else MDR <= Data_from_SRAM.
REQ-024 In RD_REL: strobes are inactive, and the FSM stays in RD_REL until Mem_OE==1, then -> IDLE (no retrigger on a held request).
REQ-025 In WR_SETUP (1 cycle): CE_n=0, WE_n=1, Data_OE=1, -> WR_PULSE with cnt reloaded to WAIT_STATES.
REQ-026 In WR_PULSE: CE_n=0, WE_n=0, Data_OE=1, lasting WAIT_STATES+1 cycles, then -> WR_HOLD.
REQ-027 In WR_HOLD (1 cycle): CE_n=0, WE_n=1, Data_OE=1, Mem_Ready=1, -> WR_REL.
REQ-028 In WR_REL: the FSM stays until Mem_WE==1, then -> IDLE.
REQ-029 A write to IO_ADDR SHALL keep SRAM_WE_n=1 and SRAM_CE_n=1 throughout, and load HEX_Data <= data_lat in WR_HOLD.
REQ-030 LD_MAR=1 SHALL load MAR <= Bus in any state.
REQ-031 LD_MDR=1 with Mem_OE==1 SHALL load MDR <= Bus.
REQ-032 LD_MDR=1 with Mem_OE==0 SHALL be ignored, because the memory capture in RD_CAP owns MDR.
REQ-033 If the RD_CAP capture and LD_MDR coincide, the capture SHALL win.
REQ-034 All SRAM strobes SHALL be registered (no combinational glitches) and inactive (1) in IDLE and the *_REL states.
REQ-035 Mem_Ready SHALL be asserted only in RD_CAP and WR_HOLD, and 0 elsewhere.

Reset
REQ-036 Reset_n=0 SHALL immediately force state=IDLE and CE_n/OE_n/WE_n=1.
REQ-037 Reset_n=0 SHALL immediately force Data_OE=0, Mem_Ready=0, cnt=0 and MAR/MDR/HEX_Data/addr_lat/data_lat=0, regardless of Clk.
REQ-038 A reset during any access SHALL abort it with no further strobe activity.
REQ-039 After Reset_n deasserts, the first edge SHALL evaluate IDLE transitions normally.

Verification
REQ-040 Read: WAIT_STATES=1, MAR=16'h0010, SRAM returns 16'h1234, Mem_OE held low -> OE_n low 2 cycles (RD_WAIT) +1 (RD_CAP), MDR=16'h1234, one Mem_Ready pulse, no second access until Mem_OE returns high.
REQ-041 Write: MAR=16'h0020, MDR=16'hBEEF, Mem_WE low -> WR_SETUP 1, WE_n low 2 cycles, WR_HOLD 1; ADDR=20'h00020 and Data_to_SRAM=16'hBEEF stable across all 4 cycles.
REQ-042 IO: read with MAR=16'hFFFF, Switches=16'h00A5 -> MDR=16'h00A5 and SRAM_CE_n stays 1; write with MDR=16'h0042 -> HEX_Data=16'h0042 and SRAM_WE_n stays 1.
REQ-043 Collision: LD_MAR with Bus=16'h9999 mid-read -> ADDR unchanged until IDLE; LD_MDR=1 during RD_CAP -> MDR takes the SRAM data.
REQ-044 Reset mid-write: Reset_n low during WR_PULSE -> WE_n=1 and Data_OE=0 asynchronously, all registers 0, and the FSM is in IDLE.
REQ-045 Priority/boundary: Mem_OE=Mem_WE=0 together -> write sequence taken; WAIT_STATES=0 -> read 2 cycles total with WE_n low for 1 cycle.
